// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the SVGA raster generator: the 800x600 @ 60 Hz
//   default timing, derived line/frame totals, sync window bounds,
//   counter widths and the registered status-flag bundle.
//   Optional feature macro (used by vga_timing): VGA_FRAME_COUNT_EN.
//   No ports (package).
package vga_timing_pkg;

    localparam int H_VISIBLE_DEF = 800;
    localparam int H_FRONT_DEF   = 40;
    localparam int H_SYNC_DEF    = 128;
    localparam int H_BACK_DEF    = 88;
    localparam int V_VISIBLE_DEF = 600;
    localparam int V_FRONT_DEF   = 1;
    localparam int V_SYNC_DEF    = 4;
    localparam int V_BACK_DEF    = 23;

    localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF; // 1056
    localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF; // 628

    // Sync windows are half-open: [start, end)
    localparam int HSYNC_START_DEF = H_VISIBLE_DEF + H_FRONT_DEF;     // 840
    localparam int HSYNC_END_DEF   = HSYNC_START_DEF + H_SYNC_DEF;    // 968
    localparam int VSYNC_START_DEF = V_VISIBLE_DEF + V_FRONT_DEF;     // 601
    localparam int VSYNC_END_DEF   = VSYNC_START_DEF + V_SYNC_DEF;    // 605

    localparam int X_W     = 11;
    localparam int Y_W     = 10;
    localparam int FRAME_W = 16;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
        logic start_update;
    } timing_flags_t;

    // Maps a logical "sync asserted" onto the pin level for the chosen polarity.
    function automatic logic sync_level(input logic asserted, input int active_high);
        return (active_high != 0) ? asserted : ~asserted;
    endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// timing_axis_counter
//   Generic wrapping counter for one raster axis. Counts 0..MAX_VAL,
//   advancing only when inc_en is high, and wraps to 0 after MAX_VAL.
//   Ports:
//     clk        in   clock
//     rst        in   synchronous active-high reset (count -> 0)
//     inc_en     in   advance the count this cycle
//     count      out  registered count
//     count_next out  value the count takes on the next edge (ignoring rst),
//                     so the parent can register decodes aligned with count
//     wrap       out  high when this cycle's advance wraps MAX_VAL -> 0
module timing_axis_counter #(
    parameter int W       = 11,
    parameter int MAX_VAL = 1055
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        wrap    = inc_en && (count_q == W'(MAX_VAL));
        count_d = count_q;
        if (wrap) begin
            count_d = '0;
        end else if (inc_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/vga_timing.sv
// vga_timing
//   Free-running SVGA raster timing generator, one pixel per clock.
//   All outputs are registered and describe the pixel shown on PIXEL_X/Y
//   in the same cycle; decodes are therefore taken from next-state counts.
//   START_UPDATE pulses once per frame at (0, V_VISIBLE), the first pixel
//   of vertical blanking, so game state changes never tear a visible frame.
//   Optional feature macro: VGA_FRAME_COUNT_EN adds the FRAME_COUNT port.
//   Ports:
//     CLK           in   pixel clock
//     RESET         in   synchronous active-high reset
//     HSYNC, VSYNC  out  syncs, polarity set by SYNC_ACTIVE_HIGH
//     BLANK         out  high outside the visible area
//     PIXEL_X       out  horizontal count 0..H_TOTAL-1
//     PIXEL_Y       out  vertical count 0..V_TOTAL-1
//     START_UPDATE  out  one-cycle pulse at start of vertical blanking
//     FRAME_COUNT   out  frames completed (only with VGA_FRAME_COUNT_EN)
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE        = H_VISIBLE_DEF,
    parameter int H_FRONT          = H_FRONT_DEF,
    parameter int H_SYNC           = H_SYNC_DEF,
    parameter int H_BACK           = H_BACK_DEF,
    parameter int V_VISIBLE        = V_VISIBLE_DEF,
    parameter int V_FRONT          = V_FRONT_DEF,
    parameter int V_SYNC           = V_SYNC_DEF,
    parameter int V_BACK           = V_BACK_DEF,
    parameter int SYNC_ACTIVE_HIGH = 1
) (
    input  logic               CLK,
    input  logic               RESET,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               BLANK,
    output logic [X_W-1:0]     PIXEL_X,
    output logic [Y_W-1:0]     PIXEL_Y,
    output logic               START_UPDATE
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [FRAME_W-1:0] FRAME_COUNT
`endif
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [X_W-1:0] X_HS_START = X_W'(HS_START);
    localparam logic [X_W-1:0] X_HS_END   = X_W'(HS_END);
    localparam logic [X_W-1:0] X_VISIBLE  = X_W'(H_VISIBLE);
    localparam logic [Y_W-1:0] Y_VS_START = Y_W'(VS_START);
    localparam logic [Y_W-1:0] Y_VS_END   = Y_W'(VS_END);
    localparam logic [Y_W-1:0] Y_VISIBLE  = Y_W'(V_VISIBLE);

    localparam logic SYNC_IDLE = (SYNC_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    logic [X_W-1:0] x_q;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] y_d;
    logic           h_wrap;
    logic           v_wrap_unused;

    timing_axis_counter #(.W(X_W), .MAX_VAL(H_TOTAL - 1)) u_h_counter (
        .clk        (CLK),
        .rst        (RESET),
        .inc_en     (1'b1),
        .count      (x_q),
        .count_next (x_d),
        .wrap       (h_wrap)
    );

    // Vertical axis advances once per line, on the horizontal wrap.
    timing_axis_counter #(.W(Y_W), .MAX_VAL(V_TOTAL - 1)) u_v_counter (
        .clk        (CLK),
        .rst        (RESET),
        .inc_en     (h_wrap),
        .count      (y_q),
        .count_next (y_d),
        .wrap       (v_wrap_unused)
    );

    timing_flags_t flags_q;
    timing_flags_t flags_d;

    always_comb begin
        flags_d              = '0;
        flags_d.hsync        = sync_level((x_d >= X_HS_START) && (x_d < X_HS_END), SYNC_ACTIVE_HIGH);
        flags_d.vsync        = sync_level((y_d >= Y_VS_START) && (y_d < Y_VS_END), SYNC_ACTIVE_HIGH);
        flags_d.blank        = (x_d >= X_VISIBLE) || (y_d >= Y_VISIBLE);
        flags_d.start_update = (x_d == '0) && (y_d == Y_VISIBLE);
    end

    // Reset has priority, so a pulse due on the reset edge is dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= '{hsync: SYNC_IDLE, vsync: SYNC_IDLE, blank: 1'b0, start_update: 1'b0};
        end else begin
            flags_q <= flags_d;
        end
    end

    assign HSYNC        = flags_q.hsync;
    assign VSYNC        = flags_q.vsync;
    assign BLANK        = flags_q.blank;
    assign START_UPDATE = flags_q.start_update;
    assign PIXEL_X      = x_q;
    assign PIXEL_Y      = y_q;

`ifdef VGA_FRAME_COUNT_EN
    logic [FRAME_W-1:0] frame_count_q;
    logic [FRAME_W-1:0] frame_count_d;

    // Counts up in the same cycle START_UPDATE is shown; wraps naturally.
    always_comb begin
        frame_count_d = frame_count_q;
        if (flags_d.start_update) begin
            frame_count_d = frame_count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign FRAME_COUNT = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing
//   Scoreboard bench for vga_timing. Two instances share one clock:
//     dut_b - default 800x600 timing, active-high syncs; checked against a
//             table of hand-computed vectors over the first two lines.
//     dut_s - shrunken raster (25 x 12 clocks, active-low syncs) so whole
//             frames, frame wrap, mid-frame reset and START_UPDATE spacing
//             fit in a short run; checked every cycle.
//   Optional feature macro: VGA_FRAME_COUNT_EN (adds FRAME_COUNT checks).
module tb_vga_timing;

    typedef struct {
        int unsigned cyc;
        logic [10:0] x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        su;
        logic [15:0] fc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b, rst_s;
    logic        hs_b, vs_b, bl_b, su_b, hs_s, vs_s, bl_s, su_s;
    logic [10:0] x_b, x_s;
    logic [9:0]  y_b, y_s;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_b, fc_s;
`endif

    vga_timing dut_b (
        .CLK          (clk),
        .RESET        (rst_b),
        .HSYNC        (hs_b),
        .VSYNC        (vs_b),
        .BLANK        (bl_b),
        .PIXEL_X      (x_b),
        .PIXEL_Y      (y_b),
        .START_UPDATE (su_b)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .FRAME_COUNT  (fc_b)
`endif
    );

    vga_timing #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
        .SYNC_ACTIVE_HIGH(0)
    ) dut_s (
        .CLK          (clk),
        .RESET        (rst_s),
        .HSYNC        (hs_s),
        .VSYNC        (vs_s),
        .BLANK        (bl_s),
        .PIXEL_X      (x_s),
        .PIXEL_Y      (y_s),
        .START_UPDATE (su_s)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .FRAME_COUNT  (fc_s)
`endif
    );

    exp_t        q_b[$];
    exp_t        q_s[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Small raster: H 16+2+4+3 = 25, V 6+1+2+3 = 12, frame = 300 clocks.
    // HSYNC low for x in [18,22), VSYNC low for y in [7,9), pulse at (0,6).
    // k = clocks since the reset edge; pre = FRAME_COUNT preloaded after k=100.
    function automatic exp_t mk_s(input int unsigned k, input int unsigned c, input bit pre);
        exp_t e;
        int unsigned f, x, y, frames;
        f      = k % 300;
        x      = f % 25;
        y      = f / 25;
        frames = (k + 150) / 300;
        e.cyc  = c;
        e.x    = 11'(x);
        e.y    = 10'(y);
        e.hs   = !((x >= 18) && (x < 22));
        e.vs   = !((y >= 7) && (y < 9));
        e.bl   = (x >= 16) || (y >= 6);
        e.su   = (x == 0) && (y == 6);
        e.fc   = 16'(frames);
        if (pre && k > 100) e.fc = 16'hFFFF + 16'(frames);
        return e;
    endfunction

    task automatic push_b(input int unsigned c, input int x, input int y,
                          input logic hs, input logic vs, input logic bl, input logic su);
        exp_t e;
        e.cyc = c; e.x = 11'(x); e.y = 10'(y);
        e.hs = hs; e.vs = vs; e.bl = bl; e.su = su; e.fc = 16'h0;
        q_b.push_back(e);
    endtask

    task automatic check(input string nm, input exp_t e, input exp_t a);
        bit ok;
        checks++;
        ok = (e.cyc == a.cyc) && (a.x == e.x) && (a.y == e.y) && (a.hs == e.hs) &&
             (a.vs == e.vs) && (a.bl == e.bl) && (a.su == e.su);
`ifdef VGA_FRAME_COUNT_EN
        ok = ok && (a.fc == e.fc);
`endif
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc=%0d got x=%0d y=%0d hs=%b vs=%b bl=%b su=%b fc=%0d expected cyc=%0d x=%0d y=%0d hs=%b vs=%b bl=%b su=%b fc=%0d",
                     nm, a.cyc, a.x, a.y, a.hs, a.vs, a.bl, a.su, a.fc,
                     e.cyc, e.x, e.y, e.hs, e.vs, e.bl, e.su, e.fc);
        end
    endtask

    // Monitor: sample on the falling edge, pop every expectation due now.
    always @(negedge clk) begin : monitor
        exp_t e, a;
        while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            e = q_b.pop_front();
            a.cyc = cyc; a.x = x_b; a.y = y_b; a.hs = hs_b; a.vs = vs_b; a.bl = bl_b; a.su = su_b;
`ifdef VGA_FRAME_COUNT_EN
            a.fc = fc_b;
`else
            a.fc = 16'h0;
`endif
            check("svga", e, a);
        end
        while (q_s.size() > 0 && q_s[0].cyc <= cyc) begin
            e = q_s.pop_front();
            a.cyc = cyc; a.x = x_s; a.y = y_s; a.hs = hs_s; a.vs = vs_s; a.bl = bl_s; a.su = su_s;
`ifdef VGA_FRAME_COUNT_EN
            a.fc = fc_s;
`else
            a.fc = 16'h0;
`endif
            check("small", e, a);
        end
    end

    task automatic wait_cyc(input int unsigned c);
        while (cyc != c) @(negedge clk);
    endtask

    localparam int unsigned REL   = 3;          // release on the falling edge after 3 reset edges
    localparam int unsigned MID_K = 685;        // small raster at (10,3) of its third frame
    localparam int unsigned B2    = REL + MID_K + 1;

    initial begin
        rst_b = 1'b1;
        rst_s = 1'b1;

        // Reset-hold cycles, then the release cycle (k=0) showing (0,0).
        for (int c = 1; c < int'(REL); c++) begin
            push_b(c, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            q_s.push_back(mk_s(0, c, 1'b0));
        end

        // Default raster, hand-computed: k -> (x, y, hs, vs, bl, su)
        push_b(REL + 0,    0,    0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_b(REL + 1,    1,    0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_b(REL + 2,    2,    0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_b(REL + 799,  799,  0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_b(REL + 800,  800,  0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_b(REL + 839,  839,  0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_b(REL + 840,  840,  0, 1'b1, 1'b0, 1'b1, 1'b0);
        push_b(REL + 967,  967,  0, 1'b1, 1'b0, 1'b1, 1'b0);
        push_b(REL + 968,  968,  0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_b(REL + 1055, 1055, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_b(REL + 1056, 0,    1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_b(REL + 1057, 1,    1, 1'b0, 1'b0, 1'b0, 1'b0);
        push_b(REL + 1895, 839,  1, 1'b0, 1'b0, 1'b1, 1'b0);
        push_b(REL + 1896, 840,  1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_b(REL + 2023, 967,  1, 1'b1, 1'b0, 1'b1, 1'b0);
        push_b(REL + 2024, 968,  1, 1'b0, 1'b0, 1'b1, 1'b0);
        push_b(REL + 2112, 0,    2, 1'b0, 1'b0, 1'b0, 1'b0);

        // Small raster: every cycle through two frames and into the third.
        for (int unsigned k = 0; k <= MID_K; k++) q_s.push_back(mk_s(k, REL + k, 1'b0));

        wait_cyc(REL);
        rst_b = 1'b0;
        rst_s = 1'b0;

        // One-clock reset in the middle of the small raster's third frame.
        wait_cyc(REL + MID_K);
        rst_s = 1'b1;
`ifdef VGA_FRAME_COUNT_EN
        for (int unsigned k = 0; k <= 330; k++) q_s.push_back(mk_s(k, B2 + k, 1'b1));
`else
        for (int unsigned k = 0; k <= 330; k++) q_s.push_back(mk_s(k, B2 + k, 1'b0));
`endif
        wait_cyc(B2);
        rst_s = 1'b0;

`ifdef VGA_FRAME_COUNT_EN
        // Preload the frame counter to its top value ahead of the next pulse.
        wait_cyc(B2 + 100);
        #2;
        force dut_s.frame_count_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut_s.frame_count_q;
`endif

        for (int i = 0; i < 3000 && (q_b.size() > 0 || q_s.size() > 0); i++) @(negedge clk);
        if (q_b.size() > 0 || q_s.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected 0", q_b.size() + q_s.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
